reg_writeback: RTL and testbench
================================

REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and reset.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning:
 clk  in  1  system clock
 reset  in  1  async active-high reset
 res_valid  in  1  ALU result offered this cycle
 res_ready  out  1  block accepts result this cycle
 alu_result  in  8  result data
 wb_en  in  1  instruction writes a register
 wb_addr  in  3  destination register
 ram_busy  in  1  register-file write port unavailable this cycle
 we_ram  out  1  register-file write strobe
 Waddr_ram  out  3  write address
 Wdata_ram  out  8  write data
 rd_addr1  in  3  operand-1 read address
 rd_addr2  in  3  operand-2 read address
 Rdata1_ram  in  8  raw operand-1 from register file
 Rdata2_ram  in  8  raw operand-2 from register file
 fwd_data1  out  8  operand-1 after forwarding
 fwd_data2  out  8  operand-2 after forwarding
 stall  out  1  equals !res_ready

Function
REQ-003 Accepted results SHALL pass through a 2-entry in-order write queue; occupancy state is EMPTY, ONE or FULL.
REQ-004 Accept (handshake) SHALL occur when res_valid && res_ready at a rising clk edge.
REQ-005 res_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL.
REQ-006 An accepted result with wb_en=1 and wb_addr!=0 SHALL be enqueued. An accepted result with wb_en=0 or wb_addr=0 SHALL be consumed and discarded (register 0 reads as zero).
REQ-007 we_ram SHALL be 1 exactly when the queue is not EMPTY and ram_busy=0. Waddr_ram/Wdata_ram SHALL present the head entry, or 0 when EMPTY.
REQ-008 The head SHALL dequeue at each edge where we_ram=1. Minimum latency is accept edge to we_ram=1 in the following cycle.
REQ-009 Transitions: EMPTY->ONE on enqueue; ONE->FULL on enqueue without dequeue; ONE->EMPTY on dequeue without enqueue; ONE stays ONE on simultaneous enqueue and dequeue; FULL->ONE on dequeue; no enqueue occurs in FULL.
REQ-010 While ram_busy=1 the queue SHALL hold its contents unchanged, apart from a permitted enqueue.
REQ-011 fwd_dataN SHALL equal the Wdata of the youngest queued entry whose address equals rd_addrN and is nonzero. Otherwise it SHALL equal RdataN_ram. The path is combinational.
REQ-012 When rd_addrN=0, fwd_dataN SHALL be 0 regardless of the register file.
REQ-013 The block SHALL never write the register file with two entries in the same cycle, and SHALL never reorder writes to the same address.

Reset
REQ-014 Assertion of reset SHALL immediately force EMPTY, discarding all queued entries, including entries accepted in the cycle reset asserts.
REQ-015 During reset: we_ram=0, Waddr_ram=0, Wdata_ram=0, res_ready=1, stall=0.
REQ-016 While in reset, fwd_dataN SHALL pass RdataN_ram (0 for address 0).
REQ-017 Reset deassertion SHALL be synchronized by the system; the block needs no internal synchronizer.

Structure
REQ-018 Package pico_pkg SHALL hold: DATA_W=8, REG_ADDR_W=3, WBQ_DEPTH=2, and enum wbq_state_t {EMPTY, ONE, FULL}.
REQ-019 Storage, pointers and occupancy SHALL live in sub-module wb_fifo (push/pop/full/empty, entry peek ports). reg_writeback SHALL own the discard rule, RAM interface and forwarding.

Verification
REQ-020 Basic write: ram_busy=0; accept alu_result=0x5A, wb_addr=3 -> next cycle we_ram=1, Waddr_ram=3, Wdata_ram=0x5A, then EMPTY.
REQ-021 Backpressure: ram_busy=1; accept 0x11@r1, then 0x22@r2 -> res_ready=0 and stall=1. A third offer is not accepted. Release ram_busy -> r1 is written, then r2, in order.
REQ-022 Forwarding: queue holds 0x10@r4 then 0x20@r4, ram_busy=1, rd_addr1=4, Rdata1_ram=0xFF -> fwd_data1=0x20. rd_addr2=5, Rdata2_ram=0x33 -> fwd_data2=0x33.
REQ-023 Discard: accept with wb_en=0, and accept with wb_addr=0 -> no we_ram pulse; rd_addr1=0 gives fwd_data1=0.
REQ-024 Simultaneous: ONE state, ram_busy=0, accept 0x77@r6 -> old head written the same cycle, state stays ONE, next cycle r6=0x77 is written.
REQ-025 Reset mid-operation: FULL with ram_busy=1, assert reset asynchronously -> we_ram=0 and res_ready=1 immediately. After release, no stale writes occur.

Source files
------------

// File: rtl/pico_pkg.sv
// Shared types and sizing for the register write-back stage.
package pico_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 3;
    localparam int WBQ_DEPTH  = 2;
    localparam int WBQ_PTR_W  = $clog2(WBQ_DEPTH);

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Occupancy of the write-back queue.
    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } wbq_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Two-entry in-order write-back queue: storage, pointers and occupancy.
// Exposes the head (oldest) entry and, when full, the younger entry so the
// parent can forward from both.
module wb_fifo
    import pico_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  reg_addr_t push_addr,
    input  data_t     push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output reg_addr_t head_addr,
    output data_t     head_data,
    output logic      young_valid,
    output reg_addr_t young_addr,
    output data_t     young_data
);

    wbq_state_t state_q;
    wbq_state_t state_d;

    logic [WBQ_PTR_W-1:0] rd_ptr_q;
    logic [WBQ_PTR_W-1:0] wr_ptr_q;
    logic [WBQ_PTR_W-1:0] young_ptr;

    reg_addr_t mem_addr [WBQ_DEPTH];
    data_t     mem_data [WBQ_DEPTH];

    logic push_ok;
    logic pop_ok;

    // Pushes into a full queue and pops from an empty one are ignored.
    assign push_ok = push && (state_q != FULL);
    assign pop_ok  = pop  && (state_q != EMPTY);

    // Occupancy state register; reset empties the queue immediately.
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Next occupancy from the push/pop pair.
    // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (push_ok) state_d = ONE;
            ONE: begin
                if (push_ok && !pop_ok)      state_d = FULL;
                else if (!push_ok && pop_ok) state_d = EMPTY;
            end
            FULL:    if (pop_ok) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Read/write pointers advance on each accepted pop/push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + WBQ_PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + WBQ_PTR_W'(1);
        end
    end

    // Entry storage, written on push only.
    // NOTE: storage is not reset; occupancy alone decides which entries are visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_addr[wr_ptr_q] <= push_addr;
            mem_data[wr_ptr_q] <= push_data;
        end
    end

    assign young_ptr = rd_ptr_q + WBQ_PTR_W'(1);

    // Status flags and entry peeks; head reads as zero when empty.
    always_comb begin
        full        = (state_q == FULL);
        empty       = (state_q == EMPTY);
        head_addr   = empty ? '0 : mem_addr[rd_ptr_q];
        head_data   = empty ? '0 : mem_data[rd_ptr_q];
        young_valid = full;
        young_addr  = full ? mem_addr[young_ptr] : '0;
        young_data  = full ? mem_data[young_ptr] : '0;
    end

endmodule

// File: rtl/reg_writeback.sv
// Register write-back stage: accepts ALU results, drops writes that target
// nothing, drains the queue into the register file when its port is free,
// and forwards queued data to operand reads.
module reg_writeback
    import pico_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      res_valid,
    output logic      res_ready,
    input  data_t     alu_result,
    input  logic      wb_en,
    input  reg_addr_t wb_addr,
    input  logic      ram_busy,
    output logic      we_ram,
    output reg_addr_t Waddr_ram,
    output data_t     Wdata_ram,
    input  reg_addr_t rd_addr1,
    input  reg_addr_t rd_addr2,
    input  data_t     Rdata1_ram,
    input  data_t     Rdata2_ram,
    output data_t     fwd_data1,
    output data_t     fwd_data2,
    output logic      stall
);

    logic      q_full;
    logic      q_empty;
    logic      q_push;
    logic      q_pop;
    reg_addr_t head_addr;
    data_t     head_data;
    logic      young_valid;
    reg_addr_t young_addr;
    data_t     young_data;

    // Register 0 is hard-wired to zero; the younger entry wins over the head.
    function automatic data_t fwd_pick(input reg_addr_t rd, input data_t raw,
                                       input logic yv, input reg_addr_t ya, input data_t yd,
                                       input logic hv, input reg_addr_t ha, input data_t hd);
        if (rd == '0)             return '0;
        if (yv && (ya == rd))     return yd;
        if (hv && (ha == rd))     return hd;
        return raw;
    endfunction

    wb_fifo u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (q_push),
        .push_addr   (wb_addr),
        .push_data   (alu_result),
        .pop         (q_pop),
        .full        (q_full),
        .empty       (q_empty),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .young_valid (young_valid),
        .young_addr  (young_addr),
        .young_data  (young_data)
    );

    // Handshake, discard rule and single-port register-file write.
    always_comb begin
        res_ready = !q_full;
        stall     = q_full;
        q_push    = res_valid && res_ready && wb_en && (wb_addr != '0);
        we_ram    = !q_empty && !ram_busy;
        q_pop     = we_ram;
        Waddr_ram = head_addr;
        Wdata_ram = head_data;
    end

    // Operand forwarding from the queue ahead of the register file.
    always_comb begin
        fwd_data1 = fwd_pick(rd_addr1, Rdata1_ram, young_valid, young_addr, young_data,
                             !q_empty, head_addr, head_data);
        fwd_data2 = fwd_pick(rd_addr2, Rdata2_ram, young_valid, young_addr, young_data,
                             !q_empty, head_addr, head_data);
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus random
// traffic, compared against a queue-based model of the write-back behaviour.
module tb_reg_writeback;

    logic       clk;
    logic       reset;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] alu_result;
    logic       wb_en;
    logic [2:0] wb_addr;
    logic       ram_busy;
    logic       we_ram;
    logic [2:0] Waddr_ram;
    logic [7:0] Wdata_ram;
    logic [2:0] rd_addr1;
    logic [2:0] rd_addr2;
    logic [7:0] Rdata1_ram;
    logic [7:0] Rdata2_ram;
    logic [7:0] fwd_data1;
    logic [7:0] fwd_data2;
    logic       stall;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } ent_t;

    ent_t mq[$];

    reg_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .alu_result (alu_result),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .ram_busy   (ram_busy),
        .we_ram     (we_ram),
        .Waddr_ram  (Waddr_ram),
        .Wdata_ram  (Wdata_ram),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .Rdata1_ram (Rdata1_ram),
        .Rdata2_ram (Rdata2_ram),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Most recently queued value for a register, else the register file value.
    function automatic logic [7:0] ref_fwd(input logic [2:0] a, input logic [7:0] raw);
        if (a == 3'd0) return 8'h00;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].addr == a) return mq[i].data;
        return raw;
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic en, input logic [2:0] a,
                         input logic busy, input logic [2:0] r1, input logic [2:0] r2,
                         input logic [7:0] rd1, input logic [7:0] rd2);
        res_valid  = v;
        alu_result = d;
        wb_en      = en;
        wb_addr    = a;
        ram_busy   = busy;
        rd_addr1   = r1;
        rd_addr2   = r2;
        Rdata1_ram = rd1;
        Rdata2_ram = rd2;
    endtask

    task automatic idle(input logic busy);
        drive(1'b0, 8'h00, 1'b0, 3'd0, busy, 3'd1, 3'd2, 8'hC1, 8'hC2);
    endtask

    // Called at a falling edge with inputs driven: compare all outputs with
    // the model, advance one clock, update the model, return at next fall.
    task automatic step(input string tag);
        logic exp_ready;
        logic exp_we;
        ent_t h;
        #1;
        exp_ready = (mq.size() < 2);
        exp_we    = !reset && (mq.size() > 0) && !ram_busy;
        h.addr = 3'd0;
        h.data = 8'h00;
        if (mq.size() > 0) h = mq[0];
        check({tag, "_ready"}, 16'(res_ready), 16'(exp_ready));
        check({tag, "_stall"}, 16'(stall),     16'(!exp_ready));
        check({tag, "_we"},    16'(we_ram),    16'(exp_we));
        check({tag, "_waddr"}, 16'(Waddr_ram), 16'(h.addr));
        check({tag, "_wdata"}, 16'(Wdata_ram), 16'(h.data));
        check({tag, "_fwd1"},  16'(fwd_data1), 16'(ref_fwd(rd_addr1, Rdata1_ram)));
        check({tag, "_fwd2"},  16'(fwd_data2), 16'(ref_fwd(rd_addr2, Rdata2_ram)));
        @(posedge clk);
        if (reset) begin
            mq.delete();
        end else begin
            if (exp_we) void'(mq.pop_front());
            if (res_valid && exp_ready && wb_en && (wb_addr != 3'd0)) begin
                ent_t e;
                e.addr = wb_addr;
                e.data = alu_result;
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset state.
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd2, 3'd0, 8'hAB, 8'h5C);
        #1;
        check("rst_we",    16'(we_ram),    16'd0);
        check("rst_ready", 16'(res_ready), 16'd1);
        check("rst_stall", 16'(stall),     16'd0);
        check("rst_waddr", 16'(Waddr_ram), 16'd0);
        check("rst_wdata", 16'(Wdata_ram), 16'd0);
        check("rst_fwd1",  16'(fwd_data1), 16'hAB);
        check("rst_fwd2",  16'(fwd_data2), 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic write.
        drive(1'b1, 8'h5A, 1'b1, 3'd3, 1'b0, 3'd1, 3'd2, 8'h00, 8'h00);
        step("basic_acc");
        idle(1'b0);
        #1;
        check("basic_we",    16'(we_ram),    16'd1);
        check("basic_waddr", 16'(Waddr_ram), 16'd3);
        check("basic_wdata", 16'(Wdata_ram), 16'h5A);
        step("basic_wr");
        idle(1'b0);
        #1;
        check("basic_empty_we", 16'(we_ram), 16'd0);
        step("basic_post");

        // Backpressure.
        drive(1'b1, 8'h11, 1'b1, 3'd1, 1'b1, 3'd1, 3'd2, 8'h00, 8'h00);
        step("bp_a1");
        drive(1'b1, 8'h22, 1'b1, 3'd2, 1'b1, 3'd1, 3'd2, 8'h00, 8'h00);
        step("bp_a2");
        drive(1'b1, 8'h33, 1'b1, 3'd7, 1'b1, 3'd1, 3'd2, 8'h00, 8'h00);
        #1;
        check("bp_ready", 16'(res_ready), 16'd0);
        check("bp_stall", 16'(stall),     16'd1);
        step("bp_a3");
        idle(1'b0);
        #1;
        check("bp_w1_addr", 16'(Waddr_ram), 16'd1);
        check("bp_w1_data", 16'(Wdata_ram), 16'h11);
        step("bp_w1");
        idle(1'b0);
        #1;
        check("bp_w2_addr", 16'(Waddr_ram), 16'd2);
        check("bp_w2_data", 16'(Wdata_ram), 16'h22);
        step("bp_w2");
        idle(1'b0);
        #1;
        check("bp_drained", 16'(we_ram), 16'd0);
        step("bp_post");

        // Forwarding from the youngest matching entry.
        drive(1'b1, 8'h10, 1'b1, 3'd4, 1'b1, 3'd1, 3'd2, 8'h00, 8'h00);
        step("fw_a1");
        drive(1'b1, 8'h20, 1'b1, 3'd4, 1'b1, 3'd1, 3'd2, 8'h00, 8'h00);
        step("fw_a2");
        drive(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 3'd4, 3'd5, 8'hFF, 8'h33);
        #1;
        check("fw_fwd1", 16'(fwd_data1), 16'h20);
        check("fw_fwd2", 16'(fwd_data2), 16'h33);
        step("fw_hold");
        idle(1'b0);
        step("fw_d1");
        drive(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd4, 3'd4, 8'hFF, 8'hEE);
        #1;
        check("fw_after_pop", 16'(fwd_data1), 16'h20);
        step("fw_d2");

        // Discard of non-writing results.
        drive(1'b1, 8'h44, 1'b0, 3'd5, 1'b0, 3'd5, 3'd2, 8'h01, 8'h00);
        step("dis_en0");
        drive(1'b1, 8'h55, 1'b1, 3'd0, 1'b0, 3'd5, 3'd2, 8'h01, 8'h00);
        #1;
        check("dis_no_we1", 16'(we_ram), 16'd0);
        step("dis_a0");
        drive(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 3'd5, 8'h99, 8'h02);
        #1;
        check("dis_no_we2", 16'(we_ram),    16'd0);
        check("dis_fwd_r0", 16'(fwd_data1), 16'd0);
        step("dis_post");

        // Simultaneous enqueue and dequeue.
        drive(1'b1, 8'h66, 1'b1, 3'd5, 1'b0, 3'd6, 3'd5, 8'h00, 8'h00);
        step("sim_a1");
        drive(1'b1, 8'h77, 1'b1, 3'd6, 1'b0, 3'd6, 3'd5, 8'h00, 8'h00);
        #1;
        check("sim_we",    16'(we_ram),    16'd1);
        check("sim_waddr", 16'(Waddr_ram), 16'd5);
        check("sim_ready", 16'(res_ready), 16'd1);
        step("sim_both");
        idle(1'b0);
        #1;
        check("sim_w2_we",   16'(we_ram),    16'd1);
        check("sim_w2_addr", 16'(Waddr_ram), 16'd6);
        check("sim_w2_data", 16'(Wdata_ram), 16'h77);
        check("sim_ready1",  16'(res_ready), 16'd1);
        step("sim_w2");
        idle(1'b0);
        step("sim_post");

        // Asynchronous reset while full and blocked.
        drive(1'b1, 8'hA1, 1'b1, 3'd1, 1'b1, 3'd1, 3'd2, 8'h00, 8'h00);
        step("mr_a1");
        drive(1'b1, 8'hA2, 1'b1, 3'd2, 1'b1, 3'd1, 3'd2, 8'h00, 8'h00);
        step("mr_a2");
        drive(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd1, 3'd2, 8'h3C, 8'h4D);
        ram_busy = 1'b1;
        #2;
        reset = 1'b1;
        mq.delete();
        #1;
        check("mr_we",    16'(we_ram),    16'd0);
        check("mr_ready", 16'(res_ready), 16'd1);
        check("mr_stall", 16'(stall),     16'd0);
        check("mr_waddr", 16'(Waddr_ram), 16'd0);
        check("mr_fwd1",  16'(fwd_data1), 16'h3C);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd1, 3'd2, 8'h3C, 8'h4D);
            #1;
            check("mr_no_stale", 16'(we_ram), 16'd0);
            step("mr_post");
        end

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 4) != 0),
                  3'($urandom), 1'($urandom_range(0, 2) == 0), 3'($urandom), 3'($urandom),
                  8'($urandom), 8'($urandom));
            reset = ($urandom_range(0, 49) == 0);
            if (reset) mq.delete();
            step("rnd");
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
